// File: rtl/vlane_div_pkg.sv
// Shared types and op-field encoding for the vector lane divider.
package vlane_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam int OP_REM      = 0;
   localparam int OP_UNSIGNED = 1;

endpackage

// File: rtl/vlane_div_if.sv
// Operand/result handshake bundle between the lane issue logic and the divider.
interface vlane_div_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [1:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic             out_valid;
   logic             out_ack;
   logic [WIDTH-1:0] result;

   modport master (
      output opA, opB, op, in_valid, flush, out_ack,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  opA, opB, op, in_valid, flush, out_ack,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/vlane_div_step.sv
// One restoring-division iteration on magnitudes: shift {rem,quo} left and
// try subtracting the divisor from the partial remainder.
module vlane_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // rem < divisor on entry, so a non-negative trial always fits WIDTH bits
   // and the top bit of the WIDTH+1 difference is a clean borrow flag.
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, divisor};
   assign rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/vlane_divider.sv
// Iterative radix-2 DIV/DIVU/REM/REMU for one vector lane: WIDTH restoring
// steps on magnitudes, one sign-fix cycle, result held until acknowledged.
module vlane_divider
   import vlane_div_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LOG2WIDTH = 5
) (
   input logic        clk,
   input logic        reset,
   vlane_div_if.slave bus
);
   div_state_e           state;
   logic [LOG2WIDTH-1:0] cnt;
   logic [1:0]           op_r;
   logic                 sign_a;
   logic                 sign_b;
   logic                 div_zero;
   logic [WIDTH-1:0]     raw_a;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     divisor;
   logic [WIDTH-1:0]     result_r;

   logic                 neg_a;
   logic                 neg_b;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [WIDTH-1:0]     rem_nx;
   logic [WIDTH-1:0]     quo_nx;
   logic [WIDTH-1:0]     q_fix;
   logic [WIDTH-1:0]     r_fix;

   // Negating MIN gives MIN back, which read unsigned is exactly 2^(WIDTH-1).
   assign neg_a = ~bus.op[OP_UNSIGNED] & bus.opA[WIDTH-1];
   assign neg_b = ~bus.op[OP_UNSIGNED] & bus.opB[WIDTH-1];
   assign abs_a = neg_a ? -bus.opA : bus.opA;
   assign abs_b = neg_b ? -bus.opB : bus.opB;

   vlane_div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .rem_nx  (rem_nx),
      .quo_nx  (quo_nx)
   );

   assign q_fix = div_zero ? {WIDTH{1'b1}} : ((sign_a ^ sign_b) ? -quo : quo);
   assign r_fix = div_zero ? raw_a         : (sign_a ? -rem : rem);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_r     <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         raw_a    <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         result_r <= '0;
      end else if (bus.flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op_r     <= bus.op;
               sign_a   <= neg_a;
               sign_b   <= neg_b;
               div_zero <= (bus.opB == '0);
               raw_a    <= bus.opA;
               rem      <= '0;
               quo      <= abs_a;
               divisor  <= abs_b;
               cnt      <= LOG2WIDTH'(WIDTH - 1);
               state    <= CALC;
            end
            CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - 1'b1;
            end
            FIX: begin
               result_r <= op_r[OP_REM] ? r_fix : q_fix;
               state    <= DONE;
            end
            DONE: if (bus.out_ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_r;
endmodule

// File: tb/tb_vlane_divider.sv
// Self-checking bench for vlane_divider: directed table, random ops against an
// arithmetic reference, and handshake/flush/reset sequences.
module tb_vlane_divider;
   localparam int W       = 32;
   localparam int LAT     = W + 2;
   localparam int MAXWAIT = 200;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   vlane_div_if #(.WIDTH(W)) bus ();

   vlane_divider #(.WIDTH(W), .LOG2WIDTH(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic: SV / and % truncate toward zero, matching DIV/REM.
   function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] o);
      longint la, lb, q, r;
      if (b == 0) begin
         q = -1;
         r = longint'(a);
      end else begin
         if (o[1]) begin
            la = longint'({32'b0, a});
            lb = longint'({32'b0, b});
         end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
         end
         q = la / lb;
         r = la % lb;
      end
      return o[0] ? r[W-1:0] : q[W-1:0];
   endfunction

   // Caller is #1 after a posedge with the divider idle; returns #1 after accept.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
      bus.opA      = a;
      bus.opB      = b;
      bus.op       = o;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // cyc counts cycles with the accept cycle as 0.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < MAXWAIT) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic ack();
      bus.out_ack = 1'b1;
      @(posedge clk); #1;
      bus.out_ack = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o, input logic [W-1:0] exp);
      int cyc;
      chk({name, "_ready"}, W'(bus.in_ready), W'(1));
      start_op(a, b, o);
      wait_done(cyc);
      chk({name, "_lat"}, W'(cyc), W'(LAT));
      chk({name, "_res"}, bus.result, exp);
      ack();
   endtask

   initial begin
      int       cyc;
      logic     stable;
      logic     seen;
      logic [W-1:0] a, b, hold;
      logic [1:0]   o;

      vecs[0]  = '{32'd100,      32'd7,        2'b10, 32'd14};
      vecs[1]  = '{32'd100,      32'd7,        2'b11, 32'd2};
      vecs[2]  = '{32'hFFFFFFF9, 32'd2,        2'b00, 32'hFFFFFFFD};
      vecs[3]  = '{32'hFFFFFFF9, 32'd2,        2'b01, 32'hFFFFFFFF};
      vecs[4]  = '{32'h12345678, 32'd0,        2'b00, 32'hFFFFFFFF};
      vecs[5]  = '{32'h12345678, 32'd0,        2'b01, 32'h12345678};
      vecs[6]  = '{32'h12345678, 32'd0,        2'b10, 32'hFFFFFFFF};
      vecs[7]  = '{32'h12345678, 32'd0,        2'b11, 32'h12345678};
      vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 2'b00, 32'h80000000};
      vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 2'b01, 32'h00000000};
      vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h00000000};
      vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 2'b11, 32'h80000000};
      vecs[12] = '{32'd7,        32'hFFFFFFFE, 2'b00, 32'hFFFFFFFD};
      vecs[13] = '{32'd7,        32'hFFFFFFFE, 2'b01, 32'd1};
      vecs[14] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 2'b00, 32'd3};
      vecs[15] = '{32'd0,        32'd5,        2'b01, 32'd0};

      bus.opA = '0; bus.opB = '0; bus.op = '0;
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ack = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
      chk("rst_out_valid", W'(bus.out_valid), W'(0));
      chk("rst_result",    bus.result,        W'(0));
      #3 reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = 32'h80000000;
            2: a = $urandom_range(0, 300);
            default: a = -$urandom_range(0, 300);
         endcase
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            2: b = $urandom_range(1, 20);
            3: b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         o = 2'($urandom_range(0, 3));
         run_op($sformatf("rnd%0d", i), a, b, o, ref_div(a, b, o));
      end

      // in_valid during CALC is ignored; result and in_ready hold while unacked.
      start_op(32'd100, 32'd7, 2'b10);
      repeat (2) begin @(posedge clk); #1; end
      bus.opA = 32'd999; bus.opB = 32'd1; bus.op = 2'b11; bus.in_valid = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      bus.in_valid = 1'b0;
      wait_done(cyc);
      chk("hold_lat", W'(cyc + 7), W'(LAT));
      chk("hold_res", bus.result, 32'd14);
      stable = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.result !== 32'd14 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            stable = 1'b0;
      end
      chk("hold_stable", W'(stable), W'(1));
      ack();
      chk("ack_ready",     W'(bus.in_ready),  W'(1));
      chk("ack_out_valid", W'(bus.out_valid), W'(0));
      run_op("after_ack", 32'hFFFFFF9C, 32'd7, 2'b01, ref_div(32'hFFFFFF9C, 32'd7, 2'b01));

      // flush in CALC drops back to IDLE; flush with in_valid in IDLE is not accepted.
      hold = bus.result;
      start_op(32'd1000, 32'd3, 2'b10);
      repeat (4) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("flush_ready", W'(bus.in_ready), W'(1));
      bus.flush = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_iv_ready", W'(bus.in_ready), W'(1));
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("flush_no_valid", W'(seen), W'(0));
      chk("flush_result",   bus.result, hold);

      // Asynchronous reset while DONE clears outputs before the next edge.
      start_op(32'd77, 32'd5, 2'b11);
      wait_done(cyc);
      chk("done_before_rst", bus.result, 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", W'(bus.out_valid), W'(0));
      chk("arst_result",    bus.result,        W'(0));
      chk("arst_in_ready",  W'(bus.in_ready),  W'(1));
      #3 reset = 1'b0;
      @(posedge clk); #1;
      run_op("post_rst", 32'd50, 32'd6, 2'b10, 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/vlane_divider.md
# vlane_divider

Iterative radix-2 integer divider for one vector lane, the inverse operation of the lane multiply/shift unit. Accepts a dividend/divisor pair through a valid/ready handshake and computes quotient and remainder over WIDTH cycles. Returns quotient or remainder, signed or unsigned, on a held-until-acknowledged output. Sits beside the lane multiplier in the vector datapath and is used for DIV/DIVU/REM/REMU.

## Interface
- WIDTH, 32, operand and result width
- LOG2WIDTH, 5, width of the iteration counter (log2 of WIDTH)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- opA  in  WIDTH  dividend
- opB  in  WIDTH  divisor
- op  in  2  op[0]=1 returns remainder, 0 returns quotient; op[1]=1 unsigned, 0 signed
- in_valid  in  1  operands and op valid this cycle
- in_ready  out  1  divider idle and able to accept
- flush  in  1  synchronous abort of any in-flight or pending operation
- out_valid  out  1  result valid; held until out_ack
- out_ack  in  1  consumer takes result
- result  out  WIDTH  quotient or remainder

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. in_valid & ~flush latches the following, then moves to CALC with counter=WIDTH-1:
  - op
  - sign of opA and opB (zero when unsigned)
  - |opA| into the quotient/shift register and |opB| into the divisor register
  - divide-by-zero flag (opB==0)
  - raw opA
- CALC: one restoring step per cycle:
  - Form {rem,quo} shifted left 1 and trial = rem_shifted - divisor, WIDTH+1 bits.
  - trial non-negative: rem<=trial, new quotient LSB=1. Otherwise rem kept, LSB=0.
  - counter decrements; at 0 move to FIX.
- FIX: one cycle of sign correction, then move to DONE.
  - Quotient negated if signA^signB; remainder negated if signA.
  - Divide-by-zero overrides: quotient={WIDTH{1}}, remainder=raw opA.
  - Signed MIN/-1 needs no special case: it yields quotient=MIN, remainder=0 from the magnitude path.
- FIX loads result with the quotient or remainder selected by the latched op[0].
- DONE: out_valid=1, result stable. out_ack moves to IDLE. No new operation is accepted in the same cycle as out_ack.
- flush in any state: next state IDLE, out_valid drops, result unchanged. flush with in_valid in IDLE means the operation is not accepted.
- Width rule: all magnitudes are treated as unsigned WIDTH-bit values. |MIN| is represented as 2^(WIDTH-1) unsigned.

## Timing
- Reset values:
  - state=IDLE, counter=0
  - in_ready=1, out_valid=0, result=0
  - internal registers 0
- Accept edge is cycle 0. CALC occupies cycles 1..WIDTH and FIX occupies cycle WIDTH+1.
- out_valid rises at cycle WIDTH+2 after the accept edge (34 cycles for WIDTH=32). Latency is fixed and independent of operand values, including divide-by-zero.
- in_ready=0 from the cycle after accept until the cycle after out_ack or flush.
- out_ack while out_valid=0 is ignored.
- reset asserted mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.
- Throughput: one operation per WIDTH+3 cycles minimum (ack in first DONE cycle).

## Structure
- Package vlane_div_pkg:
  - state enum {IDLE, CALC, FIX, DONE}
  - op bit positions OP_REM=0, OP_UNSIGNED=1
- Sub-module vlane_div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Parameterised by WIDTH. The divider instantiates it once and iterates it.
- Top level holds the FSM, counter, sign/zero flags and the FIX negation logic.

## Test plan
- Unsigned 100/7 with op=2'b10, then op=2'b11 -> result=14, then 2, with out_valid at exactly cycle 34 after accept.
- Signed -7/2: op=2'b00 -> 0xFFFFFFFD (-3); op=2'b01 -> 0xFFFFFFFF (-1).
- Divide by zero: opA=0x12345678, opB=0 -> quotient 0xFFFFFFFF, remainder 0x12345678, for both signed and unsigned.
- Overflow: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned same operands -> quotient 0, remainder 0x80000000.
- Handshake:
  - Hold out_ack=0 for 10 cycles: result stays stable and in_ready=0.
  - in_valid during CALC is ignored.
  - Ack, then a new operation is accepted on the next cycle.
- Abort:
  - flush at cycle 5 of CALC -> IDLE next cycle and out_valid never rises.
  - Async reset during DONE -> out_valid=0 and result=0 immediately.
